fpnew_divsqrt_result_buffer: RTL and testbench
==============================================

Name: fpnew_divsqrt_result_buffer

Overview:
- In-order result FIFO placed directly downstream of the multi-cycle divide/sqrt unit, in front of the FPU output arbiter.
- Accepts one result per handshake (result, status, extension bit, tag, aux) and releases it under downstream backpressure.
- Lets the divsqrt unit return to IDLE and start its next operation without holding in its own HOLD state.
- Flush discards all buffered entries.

Parameters:
- WIDTH, 64, result width in bits; matches the maximum enabled FP format width.
- DEPTH, 2, number of entries; power of two, >= 2.
- TagType, logic, type of the tag carried alongside each result.
- AuxType, logic, type of the aux field carried alongside each result.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, synchronous, active-low.
- result_i  in  WIDTH  result from divsqrt unit.
- status_i  in  5 (fpnew_pkg::status_t)  {NV,DZ,OF,UF,NX} flags.
- extension_bit_i  in  1  NaN-box request.
- tag_i  in  TagType  operation tag.
- aux_i  in  AuxType  auxiliary data.
- in_valid_i  in  1  upstream result valid.
- in_ready_o  out  1  buffer can accept.
- flush_i  in  1  synchronous discard of all contents.
- result_o  out  WIDTH  head entry result.
- status_o  out  5  head entry status.
- extension_bit_o  out  1  head entry extension bit.
- tag_o  out  TagType  head entry tag.
- aux_o  out  AuxType  head entry aux.
- out_valid_o  out  1  head entry valid.
- out_ready_i  in  1  downstream accepts.
- usage_o  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- busy_o  out  1  any valid entry held.

Behaviour:
- Clock and reset: single clock clk_i. Reset rst_ni is synchronous, active-low, sampled on the rising edge of clk_i.
- Reset values: write ptr = 0, read ptr = 0, count = 0, out_valid_o = 0, busy_o = 0, usage_o = 0, in_ready_o = 1 after the first edge with rst_ni = 1.
- While rst_ni = 0, in_ready_o = 0 and out_valid_o = 0, forced combinationally.
- Entry payload storage has no reset. Payload outputs are don't-care while out_valid_o = 0.
- Push: in_valid_i & in_ready_o at a clock edge writes the entry at the write ptr, increments the write ptr (mod DEPTH), and increments count.
- Pop: out_valid_o & out_ready_i at a clock edge increments the read ptr (mod DEPTH) and decrements count.
- Handshake signals:
  - in_ready_o = (count != DEPTH). It has no combinational dependence on out_ready_i, so there is no ready path through the block.
  - out_valid_o = (count != 0). Payload outputs are read combinationally from the entry at the read ptr.
- Latency: a push at edge N gives out_valid_o = 1 from edge N onward if the buffer was empty. This is one cycle of latency; there is no bypass path.
- Simultaneous push and pop:
  - Both occur when not full; count is unchanged and both pointers advance.
  - When full, no push is possible (in_ready_o = 0). A pop in that cycle makes in_ready_o = 1 from the next cycle.
- Full/empty:
  - With count = DEPTH, in_valid_i is ignored and the data is not written.
  - With count = 0, out_ready_i is ignored.
- Wrap-around: the pointers are log2(DEPTH) bits wide and wrap naturally. count disambiguates full from empty.
- Flush: when flush_i = 1 at an edge, the pointers and count are cleared to 0. Flush overrides any push or pop in the same cycle, so the pushed entry is dropped.
  - out_valid_o is forced to 0 combinationally during the flush cycle.
  - in_ready_o stays as computed from count.
- Ordering: strictly FIFO. No reordering or coalescing of results.
- busy_o = (count != 0), or 0 while flush_i = 1.
- usage_o = count.
- Valid is stable: once out_valid_o = 1, it and the payload stay stable until pop, flush or reset.

Optional Feature:
- Macro: FPNEW_DIVSQRT_RESBUF_FLAGS_EN.
- Enabled: adds input clear_flags_i (1 bit) and output fflags_acc_o (5 bits).
  - fflags_acc_o is a register reset to 0.
  - On each pop it is ORed with the status of the popped entry.
  - clear_flags_i = 1 sets it to 0, and overrides a same-cycle pop, whose flags are then lost.
  - Flush does not clear it.
- Disabled: both ports and the accumulator are absent. Behaviour is otherwise identical.

Test Plan:
- Reset then idle: hold rst_ni = 0 for 3 cycles, then release -> in_ready_o = 0 during reset; then in_ready_o = 1, out_valid_o = 0, usage_o = 0, busy_o = 0.
- Fill and drain (DEPTH = 2): out_ready_i = 0, push results 0x3FF0000000000000 (tag 1) and 0x4000000000000000 (tag 2) -> usage_o = 2, in_ready_o = 0. A third push of 0x4008000000000000 is ignored. Then out_ready_i = 1 -> tags pop in order 1, 2 over consecutive cycles, and out_valid_o = 0 afterwards.
- Simultaneous push/pop: usage_o = 1, out_ready_i = 1, push each cycle for 10 cycles with incrementing tags 0..9 -> usage_o stays 1. Output tags appear in order 0..9, delayed one cycle, with the pointers wrapping 5 times.
- Flush with push: usage_o = 2 and flush_i = 1 in the same cycle as a push with tag 7 -> out_valid_o = 0 in that cycle. Next cycle usage_o = 0, and tag 7 never appears.
- Status passthrough: push status 5'b10000 (NV) with extension_bit_i = 1 -> status_o = 5'b10000 and extension_bit_o = 1 at the head.
- Flags feature (macro defined): pop entries with status 5'b00001 then 5'b00100 -> fflags_acc_o = 5'b00101. Pulse clear_flags_i -> fflags_acc_o = 0 the next cycle.

Source files
------------

// File: rtl/fpnew_divsqrt_result_buffer.sv
// -----------------------------------------------------------------------------
// fpnew_divsqrt_result_buffer
//
// In-order result FIFO that sits between the multi-cycle divide/sqrt unit and
// the FPU output arbiter. The divsqrt unit can hand off a finished result and
// go back to IDLE straight away; the result waits here until the arbiter takes
// it. flush_i throws away everything currently held.
//
// Parameters
//   WIDTH   : result width in bits
//   DEPTH   : number of entries (power of two, >= 2)
//   TagType : type of the tag carried with each result
//   AuxType : type of the aux field carried with each result
//
// Ports
//   clk_i, rst_ni            : clock, synchronous active-low reset
//   result_i/status_i/extension_bit_i/tag_i/aux_i : incoming entry payload
//   in_valid_i / in_ready_o  : upstream handshake (ready depends only on count)
//   flush_i                  : synchronous discard of all entries
//   result_o/status_o/extension_bit_o/tag_o/aux_o : head entry payload
//   out_valid_o / out_ready_i: downstream handshake
//   usage_o                  : current occupancy 0..DEPTH
//   busy_o                   : at least one valid entry held
//
// Optional feature, enabled by defining FPNEW_DIVSQRT_RESBUF_FLAGS_EN:
//   clear_flags_i            : clears the flag accumulator (wins over a pop)
//   fflags_acc_o             : OR of the status of every popped entry
// -----------------------------------------------------------------------------
module fpnew_divsqrt_result_buffer #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 2,
    parameter type         TagType = logic,
    parameter type         AuxType = logic
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [WIDTH-1:0]           result_i,
    input  logic [4:0]                 status_i,
    input  logic                       extension_bit_i,
    input  TagType                     tag_i,
    input  AuxType                     aux_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic                       flush_i,
    output logic [WIDTH-1:0]           result_o,
    output logic [4:0]                 status_o,
    output logic                       extension_bit_o,
    output TagType                     tag_o,
    output AuxType                     aux_o,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
`ifdef FPNEW_DIVSQRT_RESBUF_FLAGS_EN
    input  logic                       clear_flags_i,
    output logic [4:0]                 fflags_acc_o,
`endif
    output logic [$clog2(DEPTH):0]     usage_o,
    output logic                       busy_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    // Pointers and occupancy
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Payload storage (intentionally not reset)
    logic [WIDTH-1:0] result_mem_q [DEPTH];
    logic [4:0]       status_mem_q [DEPTH];
    logic             ext_mem_q    [DEPTH];
    TagType           tag_mem_q    [DEPTH];
    AuxType           aux_mem_q    [DEPTH];

    logic push_s;
    logic pop_s;

    // Handshake and status outputs; reset and flush mask valid combinationally
    always_comb begin
        in_ready_o  = rst_ni & (count_q != CNT_FULL);
        out_valid_o = rst_ni & ~flush_i & (count_q != CNT_ZERO);
        busy_o      = ~flush_i & (count_q != CNT_ZERO);
        usage_o     = count_q;
        // A flush cycle never writes: the entry pushed alongside it is dropped.
        push_s      = in_valid_i & in_ready_o & ~flush_i;
        pop_s       = out_valid_o & out_ready_i;
    end

    // Head payload is read straight from the entry under the read pointer
    always_comb begin
        result_o        = result_mem_q[rptr_q];
        status_o        = status_mem_q[rptr_q];
        extension_bit_o = ext_mem_q[rptr_q];
        tag_o           = tag_mem_q[rptr_q];
        aux_o           = aux_mem_q[rptr_q];
    end

    // Next-state for pointers and occupancy
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (flush_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = CNT_ZERO;
        end else begin
            if (push_s) begin
                wptr_d = wptr_q + PTR_ONE;
            end else begin
                wptr_d = wptr_q;
            end
            if (pop_s) begin
                rptr_d = rptr_q + PTR_ONE;
            end else begin
                rptr_d = rptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= CNT_ZERO;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Payload write on an accepted push
    always_ff @(posedge clk_i) begin
        if (push_s) begin
            result_mem_q[wptr_q] <= result_i;
            status_mem_q[wptr_q] <= status_i;
            ext_mem_q[wptr_q]    <= extension_bit_i;
            tag_mem_q[wptr_q]    <= tag_i;
            aux_mem_q[wptr_q]    <= aux_i;
        end
    end

`ifdef FPNEW_DIVSQRT_RESBUF_FLAGS_EN
    logic [4:0] fflags_q, fflags_d;

    // Flag accumulator next-state; clear wins over a same-cycle pop
    always_comb begin
        fflags_d = fflags_q;
        if (clear_flags_i) begin
            fflags_d = 5'b00000;
        end else if (pop_s) begin
            fflags_d = fflags_q | status_o;
        end else begin
            fflags_d = fflags_q;
        end
    end

    // Flag accumulator register (flush leaves it alone)
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            fflags_q <= 5'b00000;
        end else begin
            fflags_q <= fflags_d;
        end
    end

    assign fflags_acc_o = fflags_q;
`endif

endmodule

// File: tb/tb_fpnew_divsqrt_result_buffer.sv
// -----------------------------------------------------------------------------
// Scoreboard bench for fpnew_divsqrt_result_buffer (DEPTH = 2).
// Stimulus is driven 1 time unit after each rising edge; a monitor samples on
// the falling edge, compares against a queue-based model of an in-order FIFO,
// and then applies the push/pop/flush that the coming edge will perform.
// -----------------------------------------------------------------------------
module tb_fpnew_divsqrt_result_buffer;

    localparam int WIDTH = 64;
    localparam int DEPTH = 2;

    typedef logic [3:0] tag_t;
    typedef logic [7:0] aux_t;

    typedef struct {
        logic [63:0] res;
        logic [4:0]  st;
        logic        ext;
        logic [3:0]  tag;
        logic [7:0]  aux;
    } ent_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [WIDTH-1:0] result_i;
    logic [4:0]       status_i;
    logic             ext_i;
    tag_t             tag_i;
    aux_t             aux_i;
    logic             in_valid;
    logic             in_ready;
    logic             flush;
    logic [WIDTH-1:0] result_o;
    logic [4:0]       status_o;
    logic             ext_o;
    tag_t             tag_o;
    aux_t             aux_o;
    logic             out_valid;
    logic             out_ready;
    logic             clear_flags;
    logic [4:0]       fflags_acc;
    logic [$clog2(DEPTH):0] usage;
    logic             busy;

    int checks = 0;
    int fails  = 0;

    ent_t       model_q[$];
    logic [4:0] flags_m;

    always #5 clk = ~clk;

    fpnew_divsqrt_result_buffer #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .TagType(tag_t), .AuxType(aux_t)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .result_i(result_i), .status_i(status_i), .extension_bit_i(ext_i),
        .tag_i(tag_i), .aux_i(aux_i),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .flush_i(flush),
        .result_o(result_o), .status_o(status_o), .extension_bit_o(ext_o),
        .tag_o(tag_o), .aux_o(aux_o),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
`ifdef FPNEW_DIVSQRT_RESBUF_FLAGS_EN
        .clear_flags_i(clear_flags), .fflags_acc_o(fflags_acc),
`endif
        .usage_o(usage), .busy_o(busy)
    );

`ifndef FPNEW_DIVSQRT_RESBUF_FLAGS_EN
    assign fflags_acc = 5'b00000;
`endif

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor / scoreboard: compare, then apply the coming edge to the model
    always @(negedge clk) begin : monitor
        int   sz;
        logic exp_ready;
        logic exp_valid;
        ent_t e;
        if (!rst_n) begin
            chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
            chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
            model_q.delete();
            flags_m = 5'b00000;
        end else begin
            sz        = model_q.size();
            exp_ready = (sz != DEPTH);
            exp_valid = (sz != 0) && !flush;
            chk("in_ready", {63'd0, in_ready}, {63'd0, exp_ready});
            chk("out_valid", {63'd0, out_valid}, {63'd0, exp_valid});
            chk("usage", 64'(usage), 64'(sz));
            chk("busy", {63'd0, busy}, {63'd0, exp_valid});
`ifdef FPNEW_DIVSQRT_RESBUF_FLAGS_EN
            chk("fflags_acc", {59'd0, fflags_acc}, {59'd0, flags_m});
`endif
            if (exp_valid) begin
                e = model_q[0];
                chk("head_result", result_o, e.res);
                chk("head_status", {59'd0, status_o}, {59'd0, e.st});
                chk("head_ext", {63'd0, ext_o}, {63'd0, e.ext});
                chk("head_tag", {60'd0, tag_o}, {60'd0, e.tag});
                chk("head_aux", {56'd0, aux_o}, {56'd0, e.aux});
            end
            if (clear_flags) flags_m = 5'b00000;
            else if (exp_valid && out_ready) flags_m = flags_m | model_q[0].st;
            if (exp_valid && out_ready) void'(model_q.pop_front());
            if (flush) begin
                model_q.delete();
            end else if (in_valid && exp_ready) begin
                e.res = result_i; e.st = status_i; e.ext = ext_i;
                e.tag = tag_i;    e.aux = aux_i;
                model_q.push_back(e);
            end
        end
    end

    // One stimulus cycle: wait for the edge, then drive new inputs
    task automatic cyc(input logic v, input logic [63:0] r, input logic [4:0] s,
                       input logic x, input logic [3:0] t, input logic [7:0] a,
                       input logic rdy, input logic fl, input logic clr);
        @(posedge clk);
        #1;
        in_valid = v; result_i = r; status_i = s; ext_i = x; tag_i = t;
        aux_i = a; out_ready = rdy; flush = fl; clear_flags = clr;
    endtask

    task automatic idle(input logic rdy);
        cyc(1'b0, 64'd0, 5'd0, 1'b0, 4'd0, 8'd0, rdy, 1'b0, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; result_i = '0; status_i = '0; ext_i = 1'b0;
        tag_i = '0; aux_i = '0; out_ready = 1'b0; flush = 1'b0; clear_flags = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(1'b0);
        idle(1'b0);

        // Fill, over-fill while full, then drain
        cyc(1'b1, 64'h3FF0000000000000, 5'd0, 1'b0, 4'd1, 8'h11, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 64'h4000000000000000, 5'd0, 1'b0, 4'd2, 8'h22, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 64'h4008000000000000, 5'd0, 1'b0, 4'd3, 8'h33, 1'b0, 1'b0, 1'b0);
        repeat (4) idle(1'b1);

        // Occupancy 1, then push and pop every cycle for tags 0..9
        cyc(1'b1, 64'hAAAA, 5'd0, 1'b0, 4'd15, 8'h00, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++)
            cyc(1'b1, 64'(100 + i), 5'd0, 1'b0, 4'(i), 8'(i), 1'b1, 1'b0, 1'b0);
        repeat (3) idle(1'b1);

        // Flush while full and pushing tag 7
        cyc(1'b1, 64'h1, 5'd0, 1'b0, 4'd5, 8'h05, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 64'h2, 5'd0, 1'b0, 4'd6, 8'h06, 1'b0, 1'b0, 1'b0);
        idle(1'b0);
        cyc(1'b1, 64'h7, 5'd0, 1'b0, 4'd7, 8'h07, 1'b1, 1'b1, 1'b0);
        repeat (3) idle(1'b1);

        // Status / extension passthrough
        cyc(1'b1, 64'h7FF8000000000000, 5'b10000, 1'b1, 4'd4, 8'h44, 1'b0, 1'b0, 1'b0);
        idle(1'b0);
        idle(1'b1);

        // Flag accumulation then clear
        cyc(1'b0, 64'd0, 5'd0, 1'b0, 4'd0, 8'd0, 1'b1, 1'b0, 1'b1);
        cyc(1'b1, 64'h10, 5'b00001, 1'b0, 4'd8, 8'h08, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 64'h20, 5'b00100, 1'b0, 4'd9, 8'h09, 1'b0, 1'b0, 1'b0);
        repeat (3) idle(1'b1);
        cyc(1'b0, 64'd0, 5'd0, 1'b0, 4'd0, 8'd0, 1'b1, 1'b0, 1'b1);
        idle(1'b1);

        // Randomized traffic with occasional flush, clear and reset
        for (int i = 0; i < 600; i++) begin
            cyc($urandom_range(0, 99) < 60, {$urandom, $urandom}, 5'($urandom),
                1'($urandom), 4'($urandom), 8'($urandom),
                $urandom_range(0, 99) < 50, $urandom_range(0, 99) < 4,
                $urandom_range(0, 99) < 5);
            if (i == 300) begin
                rst_n = 1'b0;
                idle(1'b1);
                #1 rst_n = 1'b1;
            end
        end
        idle(1'b1);
        idle(1'b1);
        @(posedge clk);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
